pixie_dma_host: RTL and testbench
=================================

PIXIE_DMA_HOST -- requirements
Module: pixie_dma_host

Interface
REQ-001 Parameter CYCLE_TICKS, default 8: clk_enable ticks per machine cycle (range 4..16).
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 clk_enable  input  1  CPU bus clock enable; all state advances only on clk & clk_enable.
REQ-005 DMAO  input  1  DMA-out request from the Pixie video block.
REQ-006 INT  input  1  interrupt request from the Pixie video block.
REQ-007 ie_set  input  1  one-cycle pulse that sets IE (RET emulation).
REQ-008 dma_base  input  16  display buffer base, loaded into R0 on interrupt acknowledge.
REQ-009 mem_data  input  8  memory read data.
REQ-010 mem_ack  input  1  memory read complete; mem_data valid in the same cycle.
REQ-011 SC  output  2  state code: 0 fetch, 1 execute, 2 DMA, 3 interrupt.
REQ-012 mem_addr  output  16  memory read address, equal to R0 during S2.
REQ-013 mem_rd  output  1  memory read request.
REQ-014 data_out  output  8  DMA byte driven to the Pixie data_in.
REQ-015 r0  output  16  current DMA pointer.
REQ-016 ie  output  1  interrupt enable flag.

Function
REQ-017 States S0, S1, S2, S3; SC SHALL equal the state index.
REQ-018 Each state SHALL last CYCLE_TICKS clk_enable ticks, counted by a tick counter reset at each state entry.
REQ-019 At the end of S0, the next state SHALL be S1, unconditionally.
REQ-020 At the end of S1 or S2, priority SHALL be: DMAO high -> S2; else INT high and ie=1 -> S3; else S0.
REQ-021 DMAO and INT SHALL be sampled only on the final tick of a state; pulses not present on that tick SHALL be ignored.
REQ-022 On S2 tick 0, mem_rd SHALL assert with mem_addr=r0, and hold until the first clk_enable cycle with mem_ack=1.
REQ-023 On mem_ack, data_out SHALL latch mem_data; mem_rd SHALL deassert on the following clock.
REQ-024 If mem_ack has not arrived by the final tick, the tick counter SHALL hold (cycle stretch) until mem_ack; the end-of-state decision is then made on the next tick.
REQ-025 At the end of each S2, r0 SHALL increment by 1 modulo 2^16 (0xFFFF -> 0x0000).
REQ-026 data_out SHALL hold its value outside S2 and update only on mem_ack.
REQ-027 At the end of S3, ie SHALL clear, r0 SHALL load dma_base, and the next state SHALL be S0.
REQ-028 ie_set SHALL set ie on any clock; if ie_set and the S3 end coincide, ie SHALL end up cleared.
REQ-029 mem_rd SHALL never assert outside S2.

Reset
REQ-030 While reset=0: state S0, SC=0, tick counter 0, r0=0x0000, data_out=0x00, mem_rd=0, mem_addr=0x0000, ie=1.
REQ-031 Reset asserted mid-S2 SHALL abort the read immediately; no increment of r0 and no latch of data_out.
REQ-032 After reset release, the first state SHALL be S0 with a full CYCLE_TICKS count.

Structure
REQ-033 The state encoding (S0..S3 as a 2-bit enum) and the default CYCLE_TICKS SHALL live in a shared pixie package used by pixie_video_studioii.
REQ-034 One sub-module, pixie_dma_fetch, SHALL own the mem_rd/mem_ack handshake and data_out latch; the sequencer and r0/ie remain in the top.

Verification
REQ-035 Reset, then idle with DMAO=INT=0 -> SC sequence 0,1,0,1, each held 8 ticks; mem_rd never high.
REQ-036 dma_base=0x0900, INT=1 with ie=1 at the end of S1 -> S3 for 8 ticks, then r0=0x0900, ie=0, SC=0.
REQ-037 DMAO held for 8 machine cycles after S1, memory returns 0xA0+n with mem_ack one tick after mem_rd -> eight S2 cycles, data_out 0xA0..0xA7 in order, r0=0x0908, then S0.
REQ-038 mem_ack delayed 12 ticks in S2 -> S2 lasts 13 ticks, data_out correct, r0 increments once.
REQ-039 r0=0xFFFF with a single S2 cycle -> r0=0x0000 afterwards; and INT+DMAO both high at the end of S1 -> S2 is taken first, S3 follows once DMAO drops.
REQ-040 reset pulsed low during S2 tick 3 -> mem_rd=0, r0=0x0000, data_out=0x00, ie=1 immediately; restart in S0.

Source files
------------

// File: rtl/pixie_pkg.sv
// Shared Pixie definitions: machine-cycle state codes, default cycle length and
// the state-transition rule used at the end of each machine cycle.
package pixie_pkg;

  typedef enum logic [1:0] {
    S0_FETCH   = 2'd0,
    S1_EXECUTE = 2'd1,
    S2_DMA     = 2'd2,
    S3_INT     = 2'd3
  } pixie_state_e;

  localparam int PIXIE_CYCLE_TICKS = 8;
  localparam int TICK_W            = 4;

  // DMA outranks interrupts; an interrupt is only taken while enabled.
  function automatic pixie_state_e pixie_next_state(input pixie_state_e cur,
                                                    input logic dmao,
                                                    input logic int_req,
                                                    input logic ie);
    pixie_state_e nxt;
    nxt = S0_FETCH;
    case (cur)
      S0_FETCH: nxt = S1_EXECUTE;
      S1_EXECUTE, S2_DMA: begin
        if (dmao)              nxt = S2_DMA;
        else if (int_req && ie) nxt = S3_INT;
        else                   nxt = S0_FETCH;
      end
      default: nxt = S0_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pixie_dma_fetch.sv
// Single-byte DMA read engine: raises mem_rd on request, waits for mem_ack on an
// enabled tick, captures the byte for the Pixie and drops the request.
module pixie_dma_fetch (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic       i_start,
  input  logic [7:0] i_mem_data,
  input  logic       i_mem_ack,
  output logic       o_mem_rd,
  output logic [7:0] o_data
);

  logic       r_rd;
  logic [7:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd   <= 1'b0;
      r_data <= 8'h00;
    end else if (clk_enable) begin
      if (r_rd && i_mem_ack) begin
        r_data <= i_mem_data;
        r_rd   <= 1'b0;
      end else if (i_start) begin
        r_rd <= 1'b1;
      end
    end
  end

  assign o_mem_rd = r_rd;
  assign o_data   = r_data;

endmodule

// File: rtl/pixie_dma_host.sv
// CDP1802-style machine-cycle sequencer servicing Pixie DMA-out and interrupt
// requests; owns the DMA pointer r0 and the interrupt-enable flag.
module pixie_dma_host
  import pixie_pkg::*;
#(
  parameter int CYCLE_TICKS = PIXIE_CYCLE_TICKS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        DMAO,
  input  logic        INT,
  input  logic        ie_set,
  input  logic [15:0] dma_base,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic [1:0]  SC,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [7:0]  data_out,
  output logic [15:0] r0,
  output logic        ie
);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CYCLE_TICKS - 1);

  pixie_state_e      r_state;
  logic [TICK_W-1:0] r_tick;
  logic [15:0]       r_r0;
  logic              r_ie;
  logic              w_busy;
  logic              w_last;
  logic              w_start;
  pixie_state_e      w_next;

  // A DMA cycle cannot end while its read is outstanding; the counter parks on the last tick.
  assign w_last  = clk_enable && (r_tick == LAST_TICK) && !((r_state == S2_DMA) && w_busy);
  assign w_next  = pixie_next_state(r_state, DMAO, INT, r_ie);
  assign w_start = w_last && (w_next == S2_DMA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S0_FETCH;
      r_tick  <= '0;
      r_r0    <= 16'h0000;
      r_ie    <= 1'b1;
    end else begin
      if (w_last && (r_state == S3_INT)) r_ie <= 1'b0;
      else if (ie_set)                   r_ie <= 1'b1;

      if (clk_enable) begin
        if (w_last) begin
          r_state <= w_next;
          r_tick  <= '0;
          if (r_state == S2_DMA)      r_r0 <= r_r0 + 16'd1;
          else if (r_state == S3_INT) r_r0 <= dma_base;
        end else if (r_tick != LAST_TICK) begin
          r_tick <= r_tick + 1'b1;
        end
      end
    end
  end

  pixie_dma_fetch u_fetch (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .i_start    (w_start),
    .i_mem_data (mem_data),
    .i_mem_ack  (mem_ack),
    .o_mem_rd   (w_busy),
    .o_data     (data_out)
  );

  assign SC       = r_state;
  assign mem_addr = (r_state == S2_DMA) ? r_r0 : 16'h0000;
  assign mem_rd   = w_busy;
  assign r0       = r_r0;
  assign ie       = r_ie;

endmodule

// File: tb/tb_pixie_dma_host.sv
// Randomised bench for pixie_dma_host: a machine-cycle-level model queues one
// expected record per state; a negedge monitor carves DUT activity into states and compares.
module tb_pixie_dma_host;

  localparam int CT = 8;

  typedef struct {
    int          state;
    int          len;
    logic [15:0] r0;
    logic        ie;
    logic [7:0]  data;
  } expSeg_t;

  logic        clk, reset, clkEnable, dmao, intReq, ieSet, memAck;
  logic [15:0] dmaBase;
  logic [7:0]  memData;
  logic [1:0]  sc;
  logic [15:0] memAddr, r0;
  logic        memRd, ie;
  logic [7:0]  dataOut;

  int errors = 0;
  int checks = 0;
  expSeg_t expQ[$];

  int          mState;
  logic [15:0] mR0;
  logic        mIe;
  logic [7:0]  mData;

  pixie_dma_host #(.CYCLE_TICKS(CT)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clkEnable),
    .DMAO       (dmao),
    .INT        (intReq),
    .ie_set     (ieSet),
    .dma_base   (dmaBase),
    .mem_data   (memData),
    .mem_ack    (memAck),
    .SC         (sc),
    .mem_addr   (memAddr),
    .mem_rd     (memRd),
    .data_out   (dataOut),
    .r0         (r0),
    .ie         (ie)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " SC"},       32'(sc),      32'd0);
    checkOutput({tag, " mem_rd"},   32'(memRd),   32'd0);
    checkOutput({tag, " mem_addr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, " r0"},       32'(r0),      32'd0);
    checkOutput({tag, " data_out"}, 32'(dataOut), 32'd0);
    checkOutput({tag, " ie"},       32'(ie),      32'd1);
  endtask

  task automatic modelReset();
    mState = 0;
    mR0    = 16'h0000;
    mIe    = 1'b1;
    mData  = 8'h00;
  endtask

  // Drives one whole machine cycle of the model's current state. Request lines carry
  // noise except on the final tick; in S2 the read is acked on enabled tick ackTick.
  task automatic applyStimulus(input bit pDmao, input bit pInt, input int ackTick,
                               input logic [7:0] ackData, input bit pIeSet);
    int      len;
    int      t;
    int      old;
    bit      en;
    expSeg_t e;
    len = (mState == 2 && ackTick >= CT - 1) ? ackTick + 2 : CT;
    e.state = mState;
    e.len   = len;
    e.r0    = mR0;
    e.ie    = mIe;
    e.data  = (mState == 2) ? ackData : mData;
    expQ.push_back(e);
    t = 0;
    while (t < len) begin
      en      = ($urandom_range(0, 3) != 0);
      ieSet   = 1'b0;
      dmao    = 1'($urandom_range(0, 1));
      intReq  = 1'($urandom_range(0, 1));
      memData = 8'($urandom);
      memAck  = 1'($urandom_range(0, 1));
      if (en) begin
        if (mState == 2 && t <= ackTick) begin
          memAck = (t == ackTick);
          if (t == ackTick) memData = ackData;
        end
        if (t == len - 1) begin
          dmao   = pDmao;
          intReq = pInt;
          ieSet  = pIeSet;
        end
      end
      clkEnable = en;
      @(posedge clk);
      #1;
      if (en) t++;
    end
    ieSet = 1'b0;
    old = mState;
    case (old)
      0: mState = 1;
      1, 2: begin
        if (old == 2) begin
          mR0   = mR0 + 16'd1;
          mData = ackData;
        end
        if (pDmao)            mState = 2;
        else if (pInt && mIe) mState = 3;
        else                  mState = 0;
      end
      default: begin
        mR0    = dmaBase;
        mState = 0;
      end
    endcase
    if (old == 3)    mIe = 1'b0;
    else if (pIeSet) mIe = 1'b1;
  endtask

  // Runs three ticks of a DMA cycle with no ack, then pulls reset inside tick 3.
  task automatic abortS2();
    for (int i = 0; i < 3; i++) begin
      clkEnable = 1'b1;
      memAck    = 1'b0;
      memData   = 8'($urandom);
      @(posedge clk);
      #1;
    end
    memAck  = 1'b1;
    memData = 8'h77;
    #1;
    reset = 1'b0;
    #1;
    checkReset("abort");
    @(posedge clk);
    #1;
    memAck = 1'b0;
    modelReset();
    reset = 1'b1;
  endtask

  // Monitor: a new state starts when SC changes or mem_rd rises (back-to-back S2).
  initial begin
    bit          started, prevEn, prevRd, badRd;
    int          curSc, curLen;
    logic [15:0] sR0, sAddr;
    logic        sIe;
    expSeg_t     e;
    started = 0; prevEn = 0; prevRd = 0; badRd = 0;
    curSc = 0; curLen = 0; sR0 = '0; sAddr = '0; sIe = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        started = 0;
        prevEn  = 0;
        prevRd  = 0;
      end else begin
        if (!started) begin
          started = 1;
          curSc = int'(sc); curLen = 0; sR0 = r0; sAddr = memAddr; sIe = ie; badRd = 0;
        end else begin
          if (prevEn) curLen++;
          if (int'(sc) != curSc || (memRd && !prevRd)) begin
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL segment: got state %0d expected no further state", curSc);
            end else begin
              e = expQ.pop_front();
              checkOutput("seg state",    32'(curSc),   32'(e.state));
              checkOutput("seg ticks",    32'(curLen),  32'(e.len));
              checkOutput("seg r0",       32'(sR0),     32'(e.r0));
              checkOutput("seg ie",       32'(sIe),     32'(e.ie));
              checkOutput("seg data_out", 32'(dataOut), 32'(e.data));
              if (e.state == 2) checkOutput("seg mem_addr", 32'(sAddr), 32'(e.r0));
              checkOutput("mem_rd outside S2", 32'(badRd), 32'd0);
            end
            curSc = int'(sc); curLen = 0; sR0 = r0; sAddr = memAddr; sIe = ie; badRd = 0;
          end
        end
        if (curSc != 2 && memRd) badRd = 1;
        prevEn = clkEnable;
        prevRd = memRd;
      end
    end
  end

  initial begin
    reset = 1'b0; clkEnable = 1'b0; dmao = 1'b0; intReq = 1'b0; ieSet = 1'b0;
    dmaBase = 16'h0000; memData = 8'h00; memAck = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkReset("por");
    reset = 1'b1;

    // Idle: S0,S1,S0,S1; the second S1 takes the enabled interrupt.
    dmaBase = 16'h0900;
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);

    // Eight DMA cycles, ack one tick after mem_rd, bytes 0xA0..0xA7.
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 8'h00, 0);
    for (int n = 0; n < 8; n++)
      applyStimulus(n < 7, 0, 1, 8'hA0 + 8'(n), 0);

    // Ack arriving on the twelfth tick of S2 stretches the cycle to 13 ticks.
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 11, 8'h5C, 0);

    // ie_set coinciding with the end of S3 still leaves ie cleared.
    dmaBase = 16'hFFFF;
    applyStimulus(0, 0, 0, 8'h00, 1);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 1);

    // r0 wraps 0xFFFF->0x0000; DMA wins over INT, INT is taken once DMAO drops.
    dmaBase = 16'h1234;
    applyStimulus(0, 0, 0, 8'h00, 1);
    applyStimulus(1, 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 2, 8'h3E, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);

    for (int i = 0; i < 60; i++) begin
      if (mState == 3) dmaBase = 16'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 13), 8'($urandom),
                    (mState == 0 || mState == 3) ? ($urandom_range(0, 2) == 0) : 1'b0);
    end

    while (mState != 1) applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 8'h00, 0);
    abortS2();

    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    clkEnable = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("queue drained", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
